// File: rtl/cache_axi_ctrl_pkg.sv
// rtl/cache_axi_ctrl_pkg.sv - shared constants and state encoding for the cache miss engine
package cache_axi_ctrl_pkg;

   localparam int         WORD_W         = 32;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [3:0] AXI_WSTRB_ALL  = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_AW,
      S_W,
      S_B,
      S_AR,
      S_R,
      S_DONE
   } state_t;

endpackage

// File: rtl/cache_axi_ctrl.sv
// rtl/cache_axi_ctrl.sv - miss engine: dirty-victim AXI write burst, then AXI read-burst refill
module cache_axi_ctrl
   import cache_axi_ctrl_pkg::*;
#(
   parameter int         LINE_WORDS = 8,
   parameter logic [3:0] AXI_ID     = 4'd0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         miss,
   input  logic                         write_back,
   input  logic [31:0]                  axi_raddr,
   input  logic [31:0]                  axi_waddr,
   input  logic [WORD_W*LINE_WORDS-1:0] wb_line,
   output logic                         refresh,
   output logic [WORD_W*LINE_WORDS-1:0] refill_line,
   output logic                         busy,
   output logic [31:0]                  araddr,
   output logic [3:0]                   arid,
   output logic [7:0]                   arlen,
   output logic [2:0]                   arsize,
   output logic [1:0]                   arburst,
   output logic                         arvalid,
   input  logic                         arready,
   input  logic [31:0]                  rdata,
   input  logic [3:0]                   rid,
   input  logic [1:0]                   rresp,
   input  logic                         rlast,
   input  logic                         rvalid,
   output logic                         rready,
   output logic [31:0]                  awaddr,
   output logic [3:0]                   awid,
   output logic [7:0]                   awlen,
   output logic [2:0]                   awsize,
   output logic [1:0]                   awburst,
   output logic                         awvalid,
   input  logic                         awready,
   output logic [31:0]                  wdata,
   output logic [3:0]                   wstrb,
   output logic                         wlast,
   output logic                         wvalid,
   input  logic                         wready,
   input  logic [1:0]                   bresp,
   input  logic                         bvalid,
   output logic                         bready
);

   localparam int                BEAT_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
   localparam logic [7:0]        BURST_LEN = 8'(LINE_WORDS - 1);

   state_t            state;
   logic [BEAT_W-1:0] beat;
   logic [31:0]       wb_buf     [LINE_WORDS];
   logic [31:0]       refill_buf [LINE_WORDS];

   // Responses and IDs are deliberately ignored: a failed beat still completes the burst.
   logic unused_resp;
   assign unused_resp = ^{rid, rresp, bresp};

   assign arid    = AXI_ID;
   assign arlen   = BURST_LEN;
   assign arsize  = AXI_SIZE_4B;
   assign arburst = AXI_BURST_INCR;
   assign awid    = AXI_ID;
   assign awlen   = BURST_LEN;
   assign awsize  = AXI_SIZE_4B;
   assign awburst = AXI_BURST_INCR;
   assign wstrb   = AXI_WSTRB_ALL;
   assign wdata   = wb_buf[beat];

   for (genvar g = 0; g < LINE_WORDS; g++) begin : g_pack
      assign refill_line[g*WORD_W +: WORD_W] = refill_buf[g];
   end

   // Line buffers carry no reset so the last refill line survives a reset.
   always_ff @(posedge clk) begin
      if (!rst && state == S_IDLE && miss) begin
         for (int i = 0; i < LINE_WORDS; i++) begin
            wb_buf[i] <= wb_line[i*WORD_W +: WORD_W];
         end
      end
      if (!rst && state == S_R && rvalid) begin
         refill_buf[beat] <= rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         beat    <= '0;
         awaddr  <= '0;
         araddr  <= '0;
         awvalid <= 1'b0;
         wvalid  <= 1'b0;
         wlast   <= 1'b0;
         bready  <= 1'b0;
         arvalid <= 1'b0;
         rready  <= 1'b0;
         refresh <= 1'b0;
         busy    <= 1'b0;
      end else begin
         refresh <= 1'b0;
         case (state)
            S_IDLE: begin
               if (miss) begin
                  awaddr <= axi_waddr;
                  araddr <= axi_raddr;
                  busy   <= 1'b1;
                  beat   <= '0;
                  if (write_back) begin
                     state   <= S_AW;
                     awvalid <= 1'b1;
                  end else begin
                     state   <= S_AR;
                     arvalid <= 1'b1;
                  end
               end
            end
            S_AW: begin
               if (awready) begin
                  state   <= S_W;
                  awvalid <= 1'b0;
                  wvalid  <= 1'b1;
                  wlast   <= (LINE_WORDS == 1);
                  beat    <= '0;
               end
            end
            S_W: begin
               if (wready) begin
                  if (beat == LAST_BEAT) begin
                     state  <= S_B;
                     wvalid <= 1'b0;
                     wlast  <= 1'b0;
                     bready <= 1'b1;
                     beat   <= '0;
                  end else begin
                     beat  <= beat + BEAT_W'(1);
                     wlast <= (beat + BEAT_W'(1) == LAST_BEAT);
                  end
               end
            end
            S_B: begin
               if (bvalid) begin
                  state   <= S_AR;
                  bready  <= 1'b0;
                  arvalid <= 1'b1;
               end
            end
            S_AR: begin
               if (arready) begin
                  state   <= S_R;
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  beat    <= '0;
               end
            end
            S_R: begin
               if (rvalid) begin
                  // rlast ends the refill even if the slave sent a short burst.
                  if (rlast) begin
                     state   <= S_DONE;
                     rready  <= 1'b0;
                     refresh <= 1'b1;
                     beat    <= '0;
                  end else begin
                     beat <= beat + BEAT_W'(1);
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_axi_ctrl.sv
// tb/tb_cache_axi_ctrl.sv - scoreboard bench for cache_axi_ctrl with randomized AXI slave
module tb_cache_axi_ctrl;

   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          miss = 1'b0;
   logic          write_back = 1'b0;
   logic [31:0]   axi_raddr = '0;
   logic [31:0]   axi_waddr = '0;
   logic [255:0]  wb_line = '0;
   logic          refresh;
   logic [255:0]  refill_line;
   logic          busy;
   logic [31:0]   araddr;
   logic [3:0]    arid;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic          arvalid;
   logic          arready = 1'b0;
   logic [31:0]   rdata = '0;
   logic [3:0]    rid = '0;
   logic [1:0]    rresp = '0;
   logic          rlast = 1'b0;
   logic          rvalid = 1'b0;
   logic          rready;
   logic [31:0]   awaddr;
   logic [3:0]    awid;
   logic [7:0]    awlen;
   logic [2:0]    awsize;
   logic [1:0]    awburst;
   logic          awvalid;
   logic          awready = 1'b0;
   logic [31:0]   wdata;
   logic [3:0]    wstrb;
   logic          wlast;
   logic          wvalid;
   logic          wready = 1'b0;
   logic [1:0]    bresp = '0;
   logic          bvalid = 1'b0;
   logic          bready;

   always #5 clk = ~clk;

   cache_axi_ctrl #(.LINE_WORDS(LW), .AXI_ID(4'd0)) dut (
      .clk(clk), .rst(rst), .miss(miss), .write_back(write_back),
      .axi_raddr(axi_raddr), .axi_waddr(axi_waddr), .wb_line(wb_line),
      .refresh(refresh), .refill_line(refill_line), .busy(busy),
      .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Scoreboard queues filled by the stimulus, drained by the monitor and slave.
   logic [31:0]  exp_aw_q [$];
   logic [32:0]  exp_w_q  [$];
   logic [31:0]  exp_ar_q [$];
   logic [255:0] exp_ref_q[$];
   logic [32:0]  r_beat_q [$];

   int   mode = 0;
   int   txn_id = 0;
   bit   cur_wb = 0;
   int   b_base = 0;
   int   n_exp_ref = 0;
   logic [255:0] model_line = '0;

   bit   aw_hs, w_hs, b_hs, ar_hs, r_hs, w_last_hs, aw_v, w_v, ar_v;
   int   stall_total = 0, w_total = 0, b_total = 0, ref_total = 0;
   bit   prev_ref = 0, aw_wait = 0, w_wait = 0, ar_wait = 0;
   logic [31:0] aw_prev, ar_prev;
   logic [32:0] w_prev;

   always @(negedge clk) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      w_last_hs = w_hs && wlast;
      aw_v = awvalid; w_v = wvalid; ar_v = arvalid;
      if (rst) begin
         aw_wait = 0; w_wait = 0; ar_wait = 0; prev_ref = 0;
      end else begin
         if ((awvalid && !awready) || (wvalid && !wready) || (bready && !bvalid) ||
             (arvalid && !arready) || (rready && !rvalid))
            stall_total++;
         if (aw_wait) check("aw_stable", {awvalid, awaddr}, {1'b1, aw_prev});
         if (w_wait)  check("w_stable", {wvalid, wlast, wdata}, {1'b1, w_prev});
         if (ar_wait) check("ar_stable", {arvalid, araddr}, {1'b1, ar_prev});
         aw_wait = awvalid && !awready; aw_prev = awaddr;
         w_wait  = wvalid && !wready;   w_prev  = {wlast, wdata};
         ar_wait = arvalid && !arready; ar_prev = araddr;
         if (aw_hs) begin
            check("aw_expected", exp_aw_q.size() != 0, 1'b1);
            if (exp_aw_q.size() != 0) check("aw_addr", awaddr, exp_aw_q.pop_front());
            check("aw_ctrl", {awid, awlen, awsize, awburst}, {4'd0, 8'd7, 3'b010, 2'b01});
         end
         if (w_hs) begin
            w_total++;
            check("w_expected", exp_w_q.size() != 0, 1'b1);
            if (exp_w_q.size() != 0) check("w_beat", {wlast, wdata}, exp_w_q.pop_front());
            check("w_strb", wstrb, 4'hF);
         end
         if (b_hs) b_total++;
         if (arvalid) check("ar_after_b", (!cur_wb) || (b_total > b_base), 1'b1);
         if (ar_hs) begin
            check("ar_expected", exp_ar_q.size() != 0, 1'b1);
            if (exp_ar_q.size() != 0) check("ar_addr", araddr, exp_ar_q.pop_front());
            check("ar_ctrl", {arid, arlen, arsize, arburst}, {4'd0, 8'd7, 3'b010, 2'b01});
         end
         if (refresh) begin
            ref_total++;
            check("refresh_pulse", prev_ref, 1'b0);
            check("ref_expected", exp_ref_q.size() != 0, 1'b1);
            if (exp_ref_q.size() != 0) check("refill_line", refill_line, exp_ref_q.pop_front());
         end
         prev_ref = refresh;
      end
   end

   // AXI slave: mode 0 always ready, mode 1 random, mode 2 three-cycle stalls plus gapped R.
   int seen_txn = 0, aw_st = 0, w_st = 0, ar_st = 0;
   bit b_pend = 0, r_active = 0;

   always @(posedge clk) begin
      #1;
      if (rst) begin
         b_pend = 0; r_active = 0; bvalid = 0; rvalid = 0; rlast = 0;
      end else begin
         if (txn_id != seen_txn) begin
            seen_txn = txn_id;
            aw_st = (mode == 2) ? 3 : 0;
            w_st  = (mode == 2) ? 3 : 0;
            ar_st = (mode == 2) ? 3 : 0;
         end
         if (aw_v && aw_st > 0) aw_st--;
         if (w_v && w_st > 0)   w_st--;
         if (ar_v && ar_st > 0) ar_st--;
         awready = (mode == 1) ? ($urandom_range(0, 3) != 0) : (aw_st == 0);
         wready  = (mode == 1) ? ($urandom_range(0, 3) != 0) : (w_st == 0);
         arready = (mode == 1) ? ($urandom_range(0, 3) != 0) : (ar_st == 0);
         if (w_last_hs) b_pend = 1;
         if (b_hs) b_pend = 0;
         if (!(bvalid && !b_hs))
            bvalid = b_pend && ((mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b1);
         bresp = 2'($urandom);
         if (ar_hs) r_active = 1;
         if (r_hs && r_beat_q.size() != 0) begin
            if (r_beat_q[0][32]) r_active = 0;
            void'(r_beat_q.pop_front());
         end
         if (!(rvalid && !r_hs)) begin
            if (r_active && r_beat_q.size() != 0 && (mode == 0 || $urandom_range(0, 2) != 0)) begin
               rvalid = 1;
               {rlast, rdata} = r_beat_q[0];
            end else begin
               rvalid = 0;
               rlast  = 0;
            end
         end
         rresp = 2'($urandom);
         rid   = 4'($urandom);
      end
   end

   function automatic logic [255:0] rand_line();
      logic [255:0] l;
      for (int i = 0; i < LW; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   task automatic run_txn(input bit wb, input logic [31:0] waddr, input logic [31:0] raddr,
                          input logic [255:0] vline, input logic [255:0] rline,
                          input int last_at, input int m, input bit hold, input bit do_reset);
      int st0, cyc, w0;
      bit got;
      @(negedge clk); #1;
      mode = m; cur_wb = wb; b_base = b_total; st0 = stall_total; w0 = w_total;
      if (wb) begin
         exp_aw_q.push_back(waddr);
         for (int i = 0; i < LW; i++) exp_w_q.push_back({i == LW - 1, vline[i*32 +: 32]});
      end
      if (!do_reset) begin
         exp_ar_q.push_back(raddr);
         for (int i = 0; i <= last_at; i++) begin
            r_beat_q.push_back({i == last_at, rline[i*32 +: 32]});
            model_line[i*32 +: 32] = rline[i*32 +: 32];
         end
         exp_ref_q.push_back(model_line);
         n_exp_ref++;
      end
      miss = 1; write_back = wb; axi_waddr = waddr; axi_raddr = raddr; wb_line = vline;
      txn_id++;
      if (do_reset) begin
         cyc = 0;
         while (w_total - w0 < 4 && cyc < 500) begin @(negedge clk); #1; cyc++; end
         check("w_beat4_reached", w_total - w0 >= 4, 1'b1);
         @(negedge clk); #1;
         check("w_beat4_data", {wvalid, wdata}, {1'b1, vline[4*32 +: 32]});
         rst = 1; miss = 0;
         @(negedge clk); #1;
         check("rst_mid_outputs",
               {awvalid, wvalid, bready, arvalid, rready, refresh, busy, awaddr, araddr}, '0);
         rst = 0;
         exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete(); exp_ref_q.delete(); r_beat_q.delete();
         return;
      end
      cyc = 0; got = 0;
      while (!got && cyc < 3000) begin @(negedge clk); #1; cyc++; got = refresh; end
      check("refresh_seen", got, 1'b1);
      if (got) check("latency", cyc, 10 + (wb ? 10 : 0) + (stall_total - st0) - (LW - 1 - last_at));
      if (hold) begin
         @(negedge clk); #1;
         check("hold_idle", {busy, refresh, arvalid, awvalid}, 4'b0);
         miss = 0;
         @(negedge clk); #1;
         check("hold_no_reaccept", {busy, refresh}, 2'b0);
      end else begin
         miss = 0;
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
      #1;
      check("refill_held", refill_line, model_line);
   endtask

   initial begin
      logic [255:0] rl, vl;
      repeat (3) @(negedge clk);
      #1;
      check("reset_outputs",
            {awvalid, wvalid, bready, arvalid, rready, refresh, busy, awaddr, araddr}, '0);
      rst = 0;

      for (int i = 0; i < LW; i++) rl[i*32 +: 32] = 32'h11 * (i + 1);
      run_txn(0, 32'h0, 32'h1FC0_0020, rand_line(), rl, 7, 0, 0, 0);
      check("clean_refill_const", refill_line,
            256'h00000088_00000077_00000066_00000055_00000044_00000033_00000022_00000011);

      for (int i = 0; i < LW; i++) vl[i*32 +: 32] = 32'hA0 + i;
      run_txn(1, 32'h0000_1040, 32'h2000_0100, vl, rand_line(), 7, 0, 0, 0);
      run_txn(1, 32'h0000_3080, 32'h0004_0040, rand_line(), rand_line(), 7, 2, 0, 0);
      run_txn(1, 32'h0000_5000, 32'h0000_6000, vl, rand_line(), 7, 0, 0, 1);
      run_txn(1, 32'h0000_5000, 32'h0000_6000, rand_line(), rand_line(), 7, 0, 0, 0);
      run_txn(0, 32'h0, 32'h0000_7020, rand_line(), rand_line(), 7, 0, 1, 0);
      run_txn(0, 32'h0, 32'h0000_8040, rand_line(), rand_line(), 5, 0, 0, 0);

      for (int t = 0; t < 20; t++) begin
         run_txn(1'($urandom_range(0, 1)), $urandom & ~32'h1F, $urandom & ~32'h1F,
                 rand_line(), rand_line(),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : 7,
                 $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
      end

      repeat (5) @(negedge clk);
      #1;
      check("queues_drained",
            exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size() + exp_ref_q.size() + r_beat_q.size(), 0);
      check("refresh_count", ref_total, n_exp_ref);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
